// File: rtl/mux_arb_defs.sv
// rtl/mux_arb_defs.sv - shared state encodings and defaults for the 2:1 arbitrated mux
package mux_arb_defs;

  localparam int WIDTH_DEF    = 32;
  localparam int MAXBURST_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_G0   = 2'b01,
    ST_G1   = 2'b10
  } arb_state_e;

  // A single-cycle burst limit still needs a 1-bit counter to stay legal.
  function automatic int cnt_width(input int maxburst);
    return (maxburst > 1) ? $clog2(maxburst) : 1;
  endfunction

endpackage

// File: rtl/mux2x1_param.sv
// rtl/mux2x1_param.sv - combinational WIDTH-bit 2:1 data selector
module mux2x1_param #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? a1 : a0;

endmodule

// File: rtl/mux2x1_arbiter.sv
// rtl/mux2x1_arbiter.sv - two-source round-robin arbiter with burst limit and registered shared output
module mux2x1_arbiter
  import mux_arb_defs::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MAXBURST = MAXBURST_DEF
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             r0,
  input  logic             r1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  output logic             g0,
  output logic             g1,
  output logic             s,
  output logic [WIDTH-1:0] y,
  output logic             v
);

  localparam int            CW       = cnt_width(MAXBURST);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAXBURST - 1);

  arb_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             v_q, v_d;
  logic [WIDTH-1:0] mux_out;

  assign g0 = (state_q == ST_G0);
  assign g1 = (state_q == ST_G1);
  assign s  = (state_q == ST_G1);
  assign y  = y_q;
  assign v  = v_q;

  mux2x1_param #(.WIDTH(WIDTH)) u_mux (
    .a0 (a0),
    .a1 (a1),
    .s  (s),
    .y  (mux_out)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (r0 && r1)  state_d = last_q ? ST_G0 : ST_G1;
        else if (r0)   state_d = ST_G0;
        else if (r1)   state_d = ST_G1;
        else           state_d = ST_IDLE;
      end
      ST_G0: begin
        if (!r0)                          state_d = r1 ? ST_G1 : ST_IDLE;
        else if (r1 && cnt_q == CNT_LAST) state_d = ST_G1;
        else                              state_d = ST_G0;
      end
      ST_G1: begin
        if (!r1)                          state_d = r0 ? ST_G0 : ST_IDLE;
        else if (r0 && cnt_q == CNT_LAST) state_d = ST_G0;
        else                              state_d = ST_G1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = '0;
    last_d = last_q;
    if (state_d != state_q) begin
      if (state_d == ST_G0) last_d = 1'b0;
      if (state_d == ST_G1) last_d = 1'b1;
    end else if (state_q != ST_IDLE) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // y only samples the mux while a grant is live, so ungranted data never appears.
  always_comb begin
    v_d = g0 | g1;
    y_d = v_d ? mux_out : y_q;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      y_q     <= '0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      y_q     <= y_d;
      v_q     <= v_d;
    end
  end

endmodule

// File: tb/tb_mux2x1_arbiter.sv
// tb/tb_mux2x1_arbiter.sv - scoreboard bench for mux2x1_arbiter at WIDTH=8, MAXBURST=4
module tb_mux2x1_arbiter;

  localparam int W  = 8;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         clrn, r0, r1, g0, g1, s, v;
  logic [W-1:0] a0, a1, y;

  typedef struct packed {
    logic         g0;
    logic         g1;
    logic         s;
    logic         v;
    logic [W-1:0] y;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  int           m_state;
  int           m_cnt;
  logic         m_last;
  logic [W-1:0] m_y;
  logic         m_v;

  mux2x1_arbiter #(.WIDTH(W), .MAXBURST(MB)) dut (
    .clk  (clk),
    .clrn (clrn),
    .r0   (r0),
    .r1   (r1),
    .a0   (a0),
    .a1   (a1),
    .g0   (g0),
    .g1   (g1),
    .s    (s),
    .y    (y),
    .v    (v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, in spec terms.
  task automatic model_edge(input logic c, input logic q0, input logic q1,
                            input logic [W-1:0] d0, input logic [W-1:0] d1);
    int nxt;
    exp_t e;
    if (!c) begin
      m_state = 0; m_cnt = 0; m_last = 1'b1; m_y = '0; m_v = 1'b0;
    end else begin
      m_v = (m_state != 0);
      if (m_state != 0) m_y = (m_state == 2) ? d1 : d0;
      case (m_state)
        1:       nxt = q0 ? ((q1 && m_cnt == MB-1) ? 2 : 1) : (q1 ? 2 : 0);
        2:       nxt = q1 ? ((q0 && m_cnt == MB-1) ? 1 : 2) : (q0 ? 1 : 0);
        default: nxt = (q0 && q1) ? (m_last ? 1 : 2) : (q0 ? 1 : (q1 ? 2 : 0));
      endcase
      if (nxt == m_state && nxt != 0) m_cnt = (m_cnt + 1) % MB;
      else                            m_cnt = 0;
      if (nxt != m_state && nxt == 1) m_last = 1'b0;
      if (nxt != m_state && nxt == 2) m_last = 1'b1;
      m_state = nxt;
    end
    e.g0 = (m_state == 1);
    e.g1 = (m_state == 2);
    e.s  = (m_state == 2);
    e.v  = m_v;
    e.y  = m_y;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic c, input logic q0, input logic q1,
                      input logic [W-1:0] d0, input logic [W-1:0] d1);
    exp_t e;
    clrn = c; r0 = q0; r1 = q1; a0 = d0; a1 = d1;
    model_edge(c, q0, q1, d0, d1);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("g0", {31'd0, g0}, {31'd0, e.g0});
      chk("g1", {31'd0, g1}, {31'd0, e.g1});
      chk("s",  {31'd0, s},  {31'd0, e.s});
      chk("v",  {31'd0, v},  {31'd0, e.v});
      chk("y",  {24'd0, y},  {24'd0, e.y});
    end
  endtask

  initial begin
    int run;
    clrn = 1'b0; r0 = 1'b0; r1 = 1'b0; a0 = '0; a1 = '0;
    m_state = 0; m_cnt = 0; m_last = 1'b1; m_y = '0; m_v = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with both requests pending, then last=1 tie-break.
    step(1'b0, 1'b1, 1'b1, 8'h3C, 8'hC3);
    step(1'b0, 1'b1, 1'b1, 8'h3C, 8'hC3);
    chk("rst_g0", {31'd0, g0}, 32'd0);
    chk("rst_v",  {31'd0, v},  32'd0);
    chk("rst_y",  {24'd0, y},  32'h00);
    step(1'b1, 1'b1, 1'b1, 8'h3C, 8'hC3);
    chk("rel_g0", {31'd0, g0}, 32'd1);
    step(1'b1, 1'b1, 1'b1, 8'h3C, 8'hC3);
    chk("rel_y_a0", {24'd0, y}, 32'h3C);

    // Lone requester is never forced off.
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    run = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h5A, 8'hA5);
      if (g1) run++;
    end
    chk("solo_g1_run", run, 10);
    chk("solo_y", {24'd0, y}, 32'hA5);

    // Both requesting: 4/4 alternation.
    for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 1'b1, 8'h11, 8'h22);

    // Early hand-over after r0 drops, then full burst for G1.
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h44, 8'h88);
    step(1'b1, 1'b1, 1'b0, 8'h44, 8'h88);
    step(1'b1, 1'b0, 1'b1, 8'h44, 8'h88);
    chk("drop_g1", {31'd0, g1}, 32'd1);
    run = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1, 8'h44, 8'h88);
      if (g1) run++;
    end
    chk("drop_g1_burst", run, 3);

    // Reset mid-G1 with cnt=2, then G0 wins re-arbitration.
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h01, 8'h02);
    step(1'b1, 1'b0, 1'b1, 8'h01, 8'h02);
    step(1'b1, 1'b0, 1'b1, 8'h01, 8'h02);
    step(1'b0, 1'b1, 1'b1, 8'h01, 8'h02);
    chk("midrst_v", {31'd0, v}, 32'd0);
    step(1'b1, 1'b1, 1'b1, 8'h01, 8'h02);
    chk("midrst_g0", {31'd0, g0}, 32'd1);

    // last=0 from IDLE: simultaneous requests go to source 1.
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h07, 8'h70);
    step(1'b1, 1'b0, 1'b0, 8'h07, 8'h70);
    step(1'b1, 1'b1, 1'b1, 8'h07, 8'h70);
    chk("last0_g1", {31'd0, g1}, 32'd1);
    chk("last0_g0", {31'd0, g0}, 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
